// File: rtl/ocr_ctrl_pkg.sv
// Shared definitions for the inference sequencer control slice:
// FSM state encoding, published status codes and SPI command bytes.
package ocr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_IMG,
    ST_COMMIT,
    ST_INFER,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [3:0] STATUS_IDLE     = 4'h0;
  localparam logic [3:0] STATUS_RX       = 4'h1;
  localparam logic [3:0] STATUS_COMMIT   = 4'h2;
  localparam logic [3:0] STATUS_DONE     = 4'h3;
  localparam logic [3:0] STATUS_BUF_FULL = 4'hC;
  localparam logic [3:0] STATUS_CS_ABORT = 4'hD;
  localparam logic [3:0] STATUS_BAD_CMD  = 4'hE;
  localparam logic [3:0] STATUS_TIMEOUT  = 4'hF;

  localparam logic [7:0] CMD_LOAD  = 8'hA0;
  localparam logic [7:0] CMD_CLEAR = 8'hC0;

  // States in which a pending SPI byte is consumed; COMMIT and INFER leave it pending.
  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_RX_IMG) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/inference_sequencer_if.sv
// SPI-receiver and image-buffer side signals of the inference sequencer.
//   master : the sequencer (consumes SPI bytes, drives buffer writes/clear)
//   slave  : the SPI receiver / image buffer side
interface inference_sequencer_if #(
  parameter int ADDR_W = 7
);
  logic [7:0]        spi_rx_data;
  logic              spi_byte_valid;
  logic              spi_cs_n;
  logic              byte_taken;
  logic              buffer_full;
  logic              buffer_write_en;
  logic [ADDR_W-1:0] buffer_write_addr;
  logic [7:0]        buffer_write_data;
  logic              clear_buffer;

  modport master (
    input  spi_rx_data, spi_byte_valid, spi_cs_n, buffer_full,
    output byte_taken, buffer_write_en, buffer_write_addr, buffer_write_data, clear_buffer
  );

  modport slave (
    output spi_rx_data, spi_byte_valid, spi_cs_n, buffer_full,
    input  byte_taken, buffer_write_en, buffer_write_addr, buffer_write_data, clear_buffer
  );
endinterface

// File: rtl/inference_watchdog.sv
// Inference watchdog: counts enabled cycles since the last clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of count and expire (priority over enable)
//   enable     : count one cycle
//   expire     : registered, high once the count has reached TIMEOUT_CYCLES-1
module inference_watchdog #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign cnt_next = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (enable) begin
      cnt    <= cnt_next;
      expire <= (cnt_next == LAST);
    end
  end
endmodule

// File: rtl/inference_sequencer.sv
// Control FSM between SPI byte receiver, 113-byte image buffer and BNN core.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (master)    : SPI byte handshake, buffer write port and buffer clear
//   result_ready/out: BNN completion and class
//   bnn_enable      : level while inference runs; bnn_clear: one-cycle pulse
//   status_code_reg : current status; result_reg/result_valid: latched class
// All outputs are registered.
module inference_sequencer
  import ocr_ctrl_pkg::*;
#(
  parameter int IMG_BYTES      = 113,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inference_sequencer_if.master bus,
  input  logic                  result_ready,
  input  logic [3:0]            result_out,
  output logic                  bnn_enable,
  output logic                  bnn_clear,
  output logic [3:0]            status_code_reg,
  output logic [3:0]            result_reg,
  output logic                  result_valid
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic              cs_n_q;
  logic              consume, cs_rise, wd_expire, wd_clear, wd_en;
  logic              taken_d, wen_d, clrbuf_d, bclr_d, bnn_en_d, rvalid_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [7:0]        wdata_d;
  logic [3:0]        status_d, result_d;

  assign consume  = bus.spi_byte_valid && !bus.byte_taken && accepts_bytes(state);
  assign cs_rise  = bus.spi_cs_n && !cs_n_q;
  assign wd_en    = (state == ST_INFER);
  assign wd_clear = !wd_en;

  inference_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    taken_d  = consume;
    wen_d    = 1'b0;
    waddr_d  = bus.buffer_write_addr;
    wdata_d  = bus.buffer_write_data;
    clrbuf_d = 1'b0;
    bclr_d   = 1'b0;
    status_d = status_code_reg;
    result_d = result_reg;
    rvalid_d = result_valid;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (consume) begin
          if (bus.spi_rx_data == CMD_LOAD) begin
            state_d  = ST_RX_IMG;
            cnt_d    = '0;
            rvalid_d = 1'b0;
            status_d = STATUS_RX;
          end else if (bus.spi_rx_data == CMD_CLEAR) begin
            state_d  = ST_IDLE;
            clrbuf_d = 1'b1;
            bclr_d   = 1'b1;
            rvalid_d = 1'b0;
            status_d = STATUS_IDLE;
          end else begin
            state_d  = ST_ERROR;
            status_d = STATUS_BAD_CMD;
          end
        end
      end
      ST_RX_IMG: begin
        // Final byte beats a coincident CS rise; an abort or overflow drops the byte.
        if (consume && cnt == LAST_ADDR) begin
          wen_d    = 1'b1;
          waddr_d  = cnt;
          wdata_d  = bus.spi_rx_data;
          state_d  = ST_COMMIT;
          status_d = STATUS_COMMIT;
        end else if (cs_rise) begin
          state_d  = ST_ERROR;
          clrbuf_d = 1'b1;
          status_d = STATUS_CS_ABORT;
        end else if (bus.buffer_full && cnt < LAST_ADDR) begin
          state_d  = ST_ERROR;
          status_d = STATUS_BUF_FULL;
        end else if (consume) begin
          wen_d   = 1'b1;
          waddr_d = cnt;
          wdata_d = bus.spi_rx_data;
          cnt_d   = cnt + ADDR_W'(1);
        end
      end
      ST_COMMIT: state_d = ST_INFER;
      ST_INFER: begin
        if (result_ready) begin
          result_d = result_out;
          rvalid_d = 1'b1;
          state_d  = ST_DONE;
          status_d = STATUS_DONE;
        end else if (wd_expire) begin
          state_d  = ST_ERROR;
          status_d = STATUS_TIMEOUT;
        end
      end
      ST_ERROR: begin
        if (consume && bus.spi_rx_data == CMD_CLEAR) begin
          state_d  = ST_IDLE;
          clrbuf_d = 1'b1;
          bclr_d   = 1'b1;
          rvalid_d = 1'b0;
          status_d = STATUS_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    bnn_en_d = (state_d == ST_INFER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      cnt                   <= '0;
      cs_n_q                <= 1'b1;
      bus.byte_taken        <= 1'b0;
      bus.buffer_write_en   <= 1'b0;
      bus.buffer_write_addr <= '0;
      bus.buffer_write_data <= '0;
      bus.clear_buffer      <= 1'b0;
      bnn_enable            <= 1'b0;
      bnn_clear             <= 1'b0;
      status_code_reg       <= STATUS_IDLE;
      result_reg            <= '0;
      result_valid          <= 1'b0;
    end else begin
      state                 <= state_d;
      cnt                   <= cnt_d;
      cs_n_q                <= bus.spi_cs_n;
      bus.byte_taken        <= taken_d;
      bus.buffer_write_en   <= wen_d;
      bus.buffer_write_addr <= waddr_d;
      bus.buffer_write_data <= wdata_d;
      bus.clear_buffer      <= clrbuf_d;
      bnn_enable            <= bnn_en_d;
      bnn_clear             <= bclr_d;
      status_code_reg       <= status_d;
      result_reg            <= result_d;
      result_valid          <= rvalid_d;
    end
  end
endmodule

// File: tb/tb_inference_sequencer.sv
// Self-checking bench for inference_sequencer: a cycle-level behavioural model
// checked every cycle, directed scenarios with literal expectations, then
// randomized frames, aborts, stray bytes and result timing.
module tb_inference_sequencer;
  localparam int IMG_BYTES = 113;
  localparam int ADDR_W    = 7;
  localparam int TIMEOUT   = 16;
  localparam int LIM       = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       result_ready = 1'b0;
  logic [3:0] result_out = '0;
  logic       bnn_enable, bnn_clear, result_valid;
  logic [3:0] status_code_reg, result_reg;
  logic       rand_full_en = 1'b0;

  inference_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  inference_sequencer #(
    .IMG_BYTES(IMG_BYTES), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .result_ready(result_ready), .result_out(result_out),
    .bnn_enable(bnn_enable), .bnn_clear(bnn_clear),
    .status_code_reg(status_code_reg), .result_reg(result_reg),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_RX = 1, M_COMMIT = 2, M_INFER = 3, M_DONE = 4, M_ERR = 5;
  int         m_st, m_cnt, m_n;
  logic       m_prev_cs;
  logic       e_taken, e_wen, e_clrbuf, e_bclr, e_bnn, e_rvalid;
  logic [6:0] e_addr;
  logic [7:0] e_wdata;
  logic [3:0] e_status, e_result;

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = 0; m_n = 0; m_prev_cs = 1'b1;
    e_taken = 0; e_wen = 0; e_clrbuf = 0; e_bclr = 0; e_bnn = 0; e_rvalid = 0;
    e_addr = '0; e_wdata = '0; e_status = 4'h0; e_result = 4'h0;
  endtask

  task automatic model_clear();
    e_clrbuf = 1; e_bclr = 1; e_rvalid = 0; m_st = M_IDLE; e_status = 4'h0;
  endtask

  task automatic model_write(input logic [7:0] d);
    e_wen = 1; e_addr = 7'(m_cnt); e_wdata = d;
  endtask

  task automatic model_step();
    logic take, rise;
    logic [7:0] d;
    d    = bus.spi_rx_data;
    take = bus.spi_byte_valid && !e_taken &&
           (m_st == M_IDLE || m_st == M_DONE || m_st == M_RX || m_st == M_ERR);
    rise = bus.spi_cs_n && !m_prev_cs;
    m_prev_cs = bus.spi_cs_n;
    e_taken = take; e_wen = 0; e_clrbuf = 0; e_bclr = 0;
    case (m_st)
      M_IDLE, M_DONE:
        if (take) begin
          if (d == 8'hA0) begin m_st = M_RX; m_cnt = 0; e_rvalid = 0; e_status = 4'h1; end
          else if (d == 8'hC0) model_clear();
          else begin m_st = M_ERR; e_status = 4'hE; end
        end
      M_RX:
        if (take && m_cnt == IMG_BYTES - 1) begin
          model_write(d); m_st = M_COMMIT; e_status = 4'h2;
        end else if (rise) begin
          m_st = M_ERR; e_status = 4'hD; e_clrbuf = 1;
        end else if (bus.buffer_full && m_cnt < IMG_BYTES - 1) begin
          m_st = M_ERR; e_status = 4'hC;
        end else if (take) begin
          model_write(d); m_cnt++;
        end
      M_COMMIT: begin m_st = M_INFER; m_n = 0; end
      M_INFER: begin
        m_n++;
        if (result_ready) begin
          e_result = result_out; e_rvalid = 1; m_st = M_DONE; e_status = 4'h3;
        end else if (m_n == TIMEOUT) begin
          m_st = M_ERR; e_status = 4'hF;
        end
      end
      M_ERR: if (take && d == 8'hC0) model_clear();
      default: ;
    endcase
    e_bnn = (m_st == M_INFER);
  endtask

  // Per-cycle comparison against the model, 1 time unit after each rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step(); else model_reset();
      #1;
      if (!rst_n) model_reset();
      chk("byte_taken", bus.byte_taken, e_taken);
      chk("buffer_write_en", bus.buffer_write_en, e_wen);
      if (e_wen) begin
        chk("buffer_write_addr", bus.buffer_write_addr, e_addr);
        chk("buffer_write_data", bus.buffer_write_data, e_wdata);
      end
      chk("clear_buffer", bus.clear_buffer, e_clrbuf);
      chk("bnn_enable", bnn_enable, e_bnn);
      chk("bnn_clear", bnn_clear, e_bclr);
      chk("status_code_reg", status_code_reg, e_status);
      chk("result_reg", result_reg, e_result);
      chk("result_valid", result_valid, e_rvalid);
      if (bus.buffer_write_en) n_writes++;
    end
  end

  // Occasional buffer_full during the randomized phase.
  initial begin
    bus.buffer_full = 1'b0;
    forever begin
      @(negedge clk);
      bus.buffer_full = rand_full_en && ($urandom_range(0, 1499) == 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 0;
    @(negedge clk);
    bus.spi_rx_data = b;
    bus.spi_byte_valid = 1'b1;
    for (int i = 0; i < LIM; i++) begin
      @(negedge clk);
      if (bus.byte_taken) begin got = 1; break; end
    end
    if (!got) chk("byte_taken_wait", bus.byte_taken, 1);
    bus.spi_byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int base);
    send_byte(8'hA0);
    for (int i = 0; i < IMG_BYTES; i++) send_byte(8'(i + base));
  endtask

  int w0, n_hi, k, abort_at;
  bit aborted;

  initial begin
    bus.spi_rx_data = '0;
    bus.spi_byte_valid = 1'b0;
    bus.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_status", status_code_reg, 4'h0);
    chk("rst_bnn_enable", bnn_enable, 0);
    chk("rst_result_valid", result_valid, 0);
    rst_n = 1'b1;

    // Full frame then result 7.
    bus.spi_cs_n = 1'b0;
    send_byte(8'hA0);
    chk("load_status", status_code_reg, 4'h1);
    w0 = n_writes;
    for (int i = 0; i < IMG_BYTES; i++) send_byte(8'(i));
    chk("last_addr", bus.buffer_write_addr, 112);
    chk("last_data", bus.buffer_write_data, 8'h70);
    chk("commit_status", status_code_reg, 4'h2);
    chk("commit_bnn_low", bnn_enable, 0);
    chk("frame_writes", n_writes - w0, 113);
    @(negedge clk);
    chk("infer_bnn_high", bnn_enable, 1);
    result_ready = 1'b1; result_out = 4'd7;
    @(negedge clk);
    result_ready = 1'b0;
    chk("result_reg_7", result_reg, 4'd7);
    chk("result_valid_1", result_valid, 1);
    chk("done_status", status_code_reg, 4'h3);
    chk("done_bnn_low", bnn_enable, 0);
    bus.spi_cs_n = 1'b1;

    // Bad command, dropped byte, clear.
    send_byte(8'h55);
    chk("bad_cmd_status", status_code_reg, 4'hE);
    send_byte(8'h12);
    chk("err_drop_status", status_code_reg, 4'hE);
    send_byte(8'hC0);
    chk("clr_clear_buffer", bus.clear_buffer, 1);
    chk("clr_bnn_clear", bnn_clear, 1);
    chk("clr_status", status_code_reg, 4'h0);
    chk("clr_result_valid", result_valid, 0);
    @(negedge clk);
    chk("clr_pulse_end_buf", bus.clear_buffer, 0);
    chk("clr_pulse_end_bnn", bnn_clear, 0);

    // CS abort after 50 bytes.
    bus.spi_cs_n = 1'b0;
    send_byte(8'hA0);
    for (int i = 0; i < 50; i++) send_byte(8'(i + 9));
    w0 = n_writes;
    @(negedge clk);
    bus.spi_cs_n = 1'b1;
    @(negedge clk);
    chk("abort_status", status_code_reg, 4'hD);
    chk("abort_clear_buffer", bus.clear_buffer, 1);
    repeat (3) @(negedge clk);
    chk("abort_no_writes", n_writes - w0, 0);
    send_byte(8'hC0);

    // Timeout: INFER lasts TIMEOUT cycles.
    bus.spi_cs_n = 1'b0;
    send_frame(3);
    n_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bnn_enable) n_hi++;
    end
    chk("timeout_bnn_cycles", n_hi, TIMEOUT);
    chk("timeout_status", status_code_reg, 4'hF);
    bus.spi_cs_n = 1'b1;
    send_byte(8'hC0);

    // Result in the same cycle as expiry: result wins.
    bus.spi_cs_n = 1'b0;
    send_frame(40);
    @(negedge clk);
    repeat (TIMEOUT - 1) @(negedge clk);
    result_ready = 1'b1; result_out = 4'hA;
    @(negedge clk);
    result_ready = 1'b0;
    chk("tie_status", status_code_reg, 4'h3);
    chk("tie_result", result_reg, 4'hA);
    chk("tie_valid", result_valid, 1);

    // Byte held pending through INFER, consumed once DONE.
    send_frame(77);
    @(negedge clk);
    bus.spi_rx_data = 8'hC0; bus.spi_byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("infer_hold_taken", bus.byte_taken, 0);
    end
    result_ready = 1'b1; result_out = 4'd5;
    @(negedge clk);
    result_ready = 1'b0;
    chk("pend_taken_low", bus.byte_taken, 0);
    chk("pend_result", result_reg, 4'd5);
    chk("pend_done_status", status_code_reg, 4'h3);
    @(negedge clk);
    chk("pend_taken_high", bus.byte_taken, 1);
    chk("pend_clear_status", status_code_reg, 4'h0);
    chk("pend_clear_valid", result_valid, 0);
    bus.spi_byte_valid = 1'b0;

    // Reset in the middle of a frame.
    send_byte(8'hA0);
    for (int i = 0; i < 30; i++) send_byte(8'(i + 100));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_status", status_code_reg, 4'h0);
    chk("mid_rst_result_reg", result_reg, 4'h0);
    chk("mid_rst_taken", bus.byte_taken, 0);
    chk("mid_rst_wen", bus.buffer_write_en, 0);
    chk("mid_rst_bnn", bnn_enable, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hA0);
    send_byte(8'h99);
    chk("restart_wen", bus.buffer_write_en, 1);
    chk("restart_addr", bus.buffer_write_addr, 0);
    chk("restart_data", bus.buffer_write_data, 8'h99);
    bus.spi_cs_n = 1'b1;
    send_byte(8'hC0);

    // Randomized frames, aborts, result timing and stray bytes.
    rand_full_en = 1'b1;
    for (int it = 0; it < 12; it++) begin
      send_byte(8'hC0);
      bus.spi_cs_n = 1'b0;
      send_byte(8'hA0);
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 112)) : 1000;
      aborted = 0;
      for (int i = 0; i < IMG_BYTES; i++) begin
        if (i == abort_at) begin
          @(negedge clk);
          bus.spi_cs_n = 1'b1;
          aborted = 1;
          break;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(8'($urandom));
      end
      if (!aborted) begin
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          if (bnn_enable) break;
        end
        k = $urandom_range(0, 18);
        repeat (k) @(negedge clk);
        result_ready = 1'b1; result_out = 4'($urandom);
        @(negedge clk);
        result_ready = 1'b0;
      end
      bus.spi_cs_n = 1'b1;
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_full_en = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
